byte_collector: RTL and testbench
=================================

BYTE_COLLECTOR -- requirements
Module: byte_collector

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, meaning first serial bit lands in out[7] (0: first bit lands in out[0]).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port clear  input  1  synchronous flush of partial and pending bytes.
REQ-005 The block SHALL have port in_bit  input  1  serial data bit.
REQ-006 The block SHALL have port in_valid  input  1  in_bit is valid this cycle.
REQ-007 The block SHALL have port in_ready  output  1  block accepts in_bit this cycle.
REQ-008 The block SHALL have port out  output  8  completed byte, feeds downstream 8-way OR reduction.
REQ-009 The block SHALL have port out_valid  output  1  out holds an unconsumed completed byte.
REQ-010 The block SHALL have port out_ready  input  1  downstream consumes out this cycle.
REQ-011 The block SHALL have port out_any  output  1  OR of out[7:0] gated by out_valid.
REQ-012 The block SHALL have port byte_count  output  8  number of bytes consumed downstream, modulo 256.

Function
REQ-013 The block SHALL accept a bit on a rising clk edge when in_valid and in_ready are both 1 (the bit handshake).
REQ-014 The block SHALL consume a byte on a rising clk edge when out_valid and out_ready are both 1 (the byte handshake).
REQ-015 The block SHALL keep a 3-bit bit counter (0..7) and an internal 8-bit shift register separate from out.
REQ-016 With MSB_FIRST=1 the shift register SHALL shift left, entering in_bit at bit 0; with MSB_FIRST=0 it SHALL shift right, entering in_bit at bit 7.
REQ-017 The block SHALL implement two states: COLLECT (out_valid=0) and FULL (out_valid=1).
REQ-018 In COLLECT, in_ready SHALL be 1.
REQ-019 In COLLECT, each bit handshake SHALL increment the bit counter.
REQ-020 On the 8th bit handshake (counter=7), the block SHALL load out with the completed byte, including that bit, wrap the counter to 0, and enter FULL at the same edge (latency 0 cycles after the 8th accepted bit).
REQ-021 In FULL, in_ready SHALL equal out_ready (combinational), so the next byte's first bit can be accepted in the same cycle the pending byte is consumed.
REQ-022 In FULL, a byte handshake SHALL return the state to COLLECT and increment byte_count; a simultaneous bit handshake SHALL be counted as bit 0 of the next byte.
REQ-023 In FULL without a byte handshake, out, out_valid, the shift register and the counter SHALL hold unchanged.
REQ-024 out SHALL change only when a byte completes; after consumption it SHALL retain its last value while out_valid=0.
REQ-025 out_any SHALL be (out[7]|...|out[0]) & out_valid.
REQ-026 byte_count SHALL wrap from 255 to 0 without any flag.
REQ-027 clear=1 SHALL, at the next edge and with priority over both handshakes, zero the bit counter and shift register, drop any pending byte (out_valid=0, state COLLECT), and leave out and byte_count unchanged.
REQ-028 While clear=1, in_ready SHALL be 0.
REQ-029 While in_valid=0, the counter and shift register SHALL hold.
REQ-030 in_bit SHALL be ignored when no bit handshake occurs.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately, without waiting for clk, force state COLLECT, bit counter 0, shift register 0x00, out=0x00, out_valid=0, out_any=0 and byte_count=0x00.
REQ-032 Reset asserted mid-byte or while FULL SHALL discard all partial and pending data.
REQ-033 After rst_n rises, the first bit handshake SHALL be bit 0 of a new byte.

Verification
REQ-034 MSB_FIRST=1, feed 1,0,1,0,0,1,1,0 with in_valid=1 and out_ready=0 -> after the 8th edge out=0xA6, out_valid=1, out_any=1, in_ready=0.
REQ-035 MSB_FIRST=0, same bit stream -> out=0x65; an all-zero byte -> out=0x00, out_valid=1, out_any=0.
REQ-036 Keep in_valid=1 and out_ready=1 continuously for 16 bits -> two bytes with no stall cycle, byte_count=2, and the first bit of byte 2 accepted on the byte-1 consume edge.
REQ-037 Feed 5 bits, pulse clear for one cycle, then feed 8 bits 0xFF -> out=0xFF with no stale bits; byte_count unchanged by the clear.
REQ-038 Pull rst_n low between clock edges while FULL with 3 bits of the next byte pending -> all outputs are 0 immediately; the next 8 bits form a fresh byte.
REQ-039 Consume 256 bytes -> byte_count wraps to 0x00.

Source files
------------

// File: rtl/byte_collector.sv
// Serial-to-parallel byte collector with valid/ready handshakes on both sides.
// A completed byte is held in out until consumed; the next byte may begin on the consume edge.
module byte_collector #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_any,
  output logic [7:0] byte_count
);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t     state, state_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] out_next, byte_count_next;
  logic [7:0] shifted;
  logic       bit_hs, byte_hs;

  // In FULL the input side only opens when the pending byte leaves this cycle.
  assign in_ready  = ~clear & ((state == COLLECT) | out_ready);
  assign out_valid = (state == FULL);
  assign out_any   = (|out) & out_valid;

  assign bit_hs  = in_valid & in_ready;
  assign byte_hs = out_valid & out_ready;
  assign shifted = (MSB_FIRST != 0) ? {shift_reg[6:0], in_bit} : {in_bit, shift_reg[7:1]};

  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift_reg;
    out_next        = out;
    byte_count_next = byte_count;
    if (clear) begin
      state_next   = COLLECT;
      bit_cnt_next = 3'd0;
      shift_next   = 8'h00;
    end else begin
      if (byte_hs) begin
        state_next      = COLLECT;
        byte_count_next = byte_count + 8'd1;
      end
      if (bit_hs) begin
        shift_next   = shifted;
        bit_cnt_next = bit_cnt + 3'd1;
        // The eighth bit goes straight into out rather than through the register.
        if (bit_cnt == 3'd7) begin
          out_next   = shifted;
          state_next = FULL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      out        <= 8'h00;
      byte_count <= 8'h00;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      shift_reg  <= shift_next;
      out        <= out_next;
      byte_count <= byte_count_next;
    end
  end

endmodule

// File: tb/tb_byte_collector.sv
// Bench for byte_collector: one MSB-first and one LSB-first instance share stimulus
// and are compared with a bit-list reference model plus directed expected values.
module tb_byte_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_bit;
  logic       in_valid;
  logic       out_ready;
  logic       rdy_a, rdy_b;
  logic [7:0] out_a, out_b;
  logic       valid_a, valid_b;
  logic       any_a, any_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  int         m_nbits;
  logic       m_bits [8];
  logic [7:0] m_out_a, m_out_b, m_cnt;
  logic       m_valid;

  always #5 clk = ~clk;

  byte_collector #(.MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy_a), .out(out_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_any(any_a), .byte_count(cnt_a)
  );

  byte_collector #(.MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(rdy_b), .out(out_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_any(any_b), .byte_count(cnt_b)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_nbits = 0;
    m_valid = 1'b0;
    m_out_a = 8'h00;
    m_out_b = 8'h00;
    m_cnt   = 8'h00;
  endtask

  // Advance one clock edge; the model consumes the inputs seen just before the edge.
  task automatic step();
    logic m_rdy, bit_hs, byte_hs;
    m_rdy   = !clear && (!m_valid || out_ready);
    bit_hs  = in_valid && m_rdy;
    byte_hs = m_valid && out_ready && !clear;
    @(posedge clk);
    if (clear) begin
      m_nbits = 0;
      m_valid = 1'b0;
    end else begin
      if (byte_hs) begin
        m_valid = 1'b0;
        m_cnt   = m_cnt + 8'd1;
      end
      if (bit_hs) begin
        m_bits[m_nbits] = in_bit;
        m_nbits++;
        if (m_nbits == 8) begin
          for (int i = 0; i < 8; i++) begin
            m_out_a[7-i] = m_bits[i];
            m_out_b[i]   = m_bits[i];
          end
          m_valid = 1'b1;
          m_nbits = 0;
        end
      end
    end
    #1;
  endtask

  task automatic send_bits(input logic [7:0] stream, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = stream[7-i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #3;
    checks++;
    if (out_a !== 8'h00 || out_b !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_out: got %h/%h, required 00/00", out_a, out_b);
    end
    checks++;
    if (valid_a !== 1'b0 || any_a !== 1'b0 || cnt_a !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_flags: valid=%b any=%b cnt=%h, required 0 0 00", valid_a, any_a, cnt_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (rdy_a !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b, required 1", rdy_a);
    end
  endtask

  task automatic test_pattern();
    out_ready = 1'b0;
    send_bits(8'hA6, 8);
    checks++;
    if (out_a !== 8'hA6 || out_b !== 8'h65) begin
      errors++; $display("[TB] FAIL pattern_out: got %h/%h, required A6/65", out_a, out_b);
    end
    checks++;
    if (valid_a !== 1'b1 || any_a !== 1'b1 || rdy_a !== 1'b0 || valid_b !== 1'b1) begin
      errors++; $display("[TB] FAIL pattern_flags: valid=%b any=%b ready=%b, required 1 1 0", valid_a, any_a, rdy_a);
    end
    in_valid = 1'b1; in_bit = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_a !== 8'hA6 || valid_a !== 1'b1 || out_b !== 8'h65) begin
      errors++; $display("[TB] FAIL pattern_hold: got %h valid=%b, required A6 valid=1", out_a, valid_a);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (valid_a !== 1'b0 || out_a !== 8'hA6 || any_a !== 1'b0 || cnt_a !== 8'd1 || cnt_b !== 8'd1) begin
      errors++; $display("[TB] FAIL pattern_consume: valid=%b out=%h any=%b cnt=%h, required 0 A6 0 01", valid_a, out_a, any_a, cnt_a);
    end
  endtask

  task automatic test_zero_byte();
    out_ready = 1'b0;
    send_bits(8'h00, 8);
    checks++;
    if (out_b !== 8'h00 || valid_b !== 1'b1 || any_b !== 1'b0 || any_a !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_byte: out=%h valid=%b any=%b, required 00 1 0", out_b, valid_b, any_b);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (cnt_a !== 8'd2) begin
      errors++; $display("[TB] FAIL zero_count: got %h, required 02", cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    logic [7:0]  exp_cnt;
    int          stalls;
    bits    = 16'($urandom);
    exp_cnt = m_cnt + 8'd2;
    stalls  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[15-i];
      if (rdy_a !== 1'b1 || rdy_b !== 1'b1) stalls++;
      if (i == 8) begin
        checks++;
        if (valid_a !== 1'b1 || rdy_a !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_overlap: valid=%b ready=%b, required 1 1", valid_a, rdy_a);
        end
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin
      errors++; $display("[TB] FAIL b2b_stall: got %0d stall cycles, required 0", stalls);
    end
    checks++;
    if (out_a !== bits[7:0] || valid_a !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_second: got %h valid=%b, required %h valid=1", out_a, valid_a, bits[7:0]);
    end
    step();
    checks++;
    if (cnt_a !== exp_cnt || cnt_b !== exp_cnt) begin
      errors++; $display("[TB] FAIL b2b_count: got %h/%h, required %h", cnt_a, cnt_b, exp_cnt);
    end
  endtask

  task automatic test_clear();
    logic [7:0] exp_cnt;
    exp_cnt   = m_cnt;
    out_ready = 1'b1;
    send_bits(8'b0101_0000, 5);
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    #1;
    checks++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_ready: got %b/%b, required 0", rdy_a, rdy_b);
    end
    step();
    clear = 1'b0;
    out_ready = 1'b0;
    send_bits(8'hFF, 8);
    checks++;
    if (out_a !== 8'hFF || out_b !== 8'hFF || valid_a !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_stale: got %h/%h valid=%b, required FF/FF valid=1", out_a, out_b, valid_a);
    end
    checks++;
    if (cnt_a !== exp_cnt) begin
      errors++; $display("[TB] FAIL clear_count: got %h, required %h", cnt_a, exp_cnt);
    end
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || out_a !== 8'hFF || cnt_a !== exp_cnt) begin
      errors++; $display("[TB] FAIL clear_full: valid=%b out=%h cnt=%h, required 0 FF %h", valid_a, out_a, cnt_a, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_bits(8'h3C, 8);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_a !== 8'h00 || valid_a !== 1'b0 || any_a !== 1'b0 || cnt_a !== 8'h00 || out_b !== 8'h00) begin
      errors++; $display("[TB] FAIL areset_full: out=%h valid=%b any=%b cnt=%h, required 00 0 0 00", out_a, valid_a, any_a, cnt_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(8'hE0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(8'hC5, 8);
    checks++;
    if (out_a !== 8'hC5 || out_b !== 8'hA3 || valid_a !== 1'b1 || cnt_a !== 8'h00) begin
      errors++; $display("[TB] FAIL areset_fresh: got %h/%h valid=%b cnt=%h, required C5/A3 1 00", out_a, out_b, valid_a, cnt_a);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      clear     = ($urandom_range(15) == 0);
      in_valid  = 1'($urandom);
      in_bit    = 1'($urandom);
      out_ready = 1'($urandom);
      #1;
      checks++;
      if (rdy_a !== (!clear && (!m_valid || out_ready)) || rdy_b !== rdy_a) begin
        errors++; $display("[TB] FAIL rand_ready: cycle %0d got %b/%b, required %b", n, rdy_a, rdy_b, !clear && (!m_valid || out_ready));
      end
      step();
      checks++;
      if (out_a !== m_out_a || out_b !== m_out_b || valid_a !== m_valid || valid_b !== m_valid) begin
        errors++; $display("[TB] FAIL rand_out: cycle %0d got %h/%h valid=%b, required %h/%h valid=%b", n, out_a, out_b, valid_a, m_out_a, m_out_b, m_valid);
      end
      checks++;
      if (any_a !== ((m_out_a != 8'h00) && m_valid) || cnt_a !== m_cnt || cnt_b !== m_cnt) begin
        errors++; $display("[TB] FAIL rand_count: cycle %0d any=%b cnt=%h, required any=%b cnt=%h", n, any_a, cnt_a, (m_out_a != 8'h00) && m_valid, m_cnt);
      end
    end
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      step();
      if (i == 2040) begin
        checks++;
        if (cnt_a !== 8'd255) begin
          errors++; $display("[TB] FAIL wrap_255: got %h, required FF", cnt_a);
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (cnt_a !== 8'h00 || cnt_b !== 8'h00 || valid_a !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_zero: got %h/%h valid=%b, required 00/00 valid=0", cnt_a, cnt_b, valid_a);
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_zero_byte();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
